// File: rtl/digital_lock_pkg.sv
// Shared encodings for the digital lock controller: state codes, state width
// and the largest legal BCD digit.
package digital_lock_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_LOCKED    = 3'd0;
    localparam logic [STATE_W-1:0] S_OPEN      = 3'd1;
    localparam logic [STATE_W-1:0] S_NEW_PW    = 3'd2;
    localparam logic [STATE_W-1:0] S_VERIFY_PW = 3'd3;
    localparam logic [STATE_W-1:0] S_LOCKOUT   = 3'd4;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        ST_LOCKED    = S_LOCKED,
        ST_OPEN      = S_OPEN,
        ST_NEW_PW    = S_NEW_PW,
        ST_VERIFY_PW = S_VERIFY_PW,
        ST_LOCKOUT   = S_LOCKOUT
    } lock_state_e;

endpackage

// File: rtl/lock_entry_reg.sv
// Digit entry shift register: newest BCD digit lands in nibble 0, non-BCD
// digits and digits beyond NUM_DIGITS are dropped.
module lock_entry_reg
    import digital_lock_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    digit_en,
    input  logic [3:0]              digit,
    output logic [4*NUM_DIGITS-1:0] entry,
    output logic [CNT_W-1:0]        count,
    output logic                    full
);

    logic [NUM_DIGITS-1:0][3:0] nib;
    logic                       accept;

    assign full   = (count == CNT_W'(NUM_DIGITS));
    assign accept = digit_en && (digit <= BCD_MAX) && !full;
    assign entry  = nib;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            nib   <= '0;
            count <= '0;
        end else if (accept) begin
            nib[0] <= digit;
            for (int i = 1; i < NUM_DIGITS; i++)
                nib[i] <= nib[i-1];
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/digital_lock_ctrl.sv
// Digital lock FSM: code check with trial budget, timed lockout, optional
// auto-relock from OPEN and two-step in-field code change.
module digital_lock_ctrl
    import digital_lock_pkg::*;
#(
    parameter int                    NUM_DIGITS     = 3,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_PW   = 12'h123,
    parameter int                    MAX_TRIALS     = 3,
    parameter int                    LOCKOUT_CYCLES = 250_000_000,
    parameter int                    OPEN_TIMEOUT   = 0,
    localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [3:0]              i_digit,
    input  logic                    i_digit_valid,
    input  logic                    i_confirm,
    input  logic                    i_change,
    input  logic                    i_clear,
    output logic [4*NUM_DIGITS-1:0] o_entry,
    output logic [CNT_W-1:0]        o_digit_count,
    output logic [STATE_W-1:0]      o_state,
    output logic [3:0]              o_trials_left,
    output logic                    o_correct,
    output logic                    o_incorrect,
    output logic                    o_mismatch,
    output logic                    o_locked_out
);

    localparam int CODE_W = 4 * NUM_DIGITS;
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int OPEN_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [OPEN_W-1:0] OPEN_LAST   = OPEN_W'((OPEN_TIMEOUT > 0) ? OPEN_TIMEOUT - 1 : 0);
    localparam logic [3:0]        TRIALS_INIT = 4'(MAX_TRIALS);

    lock_state_e        state, next_state;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  pend_q, pend_d;
    logic [3:0]         trials_q, trials_d, trials_dec;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [OPEN_W-1:0]  open_cnt;
    logic [CODE_W-1:0]  entry;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               entry_clr, digit_en;
    logic               incorrect_d, mismatch_d;
    logic               timeout_hit;

    lock_entry_reg #(.NUM_DIGITS(NUM_DIGITS)) u_entry (
        .clk      (i_clk),
        .reset    (i_reset),
        .clear    (entry_clr),
        .digit_en (digit_en),
        .digit    (i_digit),
        .entry    (entry),
        .count    (count),
        .full     (full)
    );

    assign trials_dec  = (trials_q == 4'd0) ? 4'd0 : trials_q - 4'd1;
    assign timeout_hit = (OPEN_TIMEOUT > 0) && (open_cnt == OPEN_LAST);

    // Confirm beats clear beats digit; the loser of a same-cycle pair is dropped.
    always_comb begin
        next_state  = state;
        code_d      = code_q;
        pend_d      = pend_q;
        trials_d    = trials_q;
        entry_clr   = 1'b0;
        digit_en    = 1'b0;
        incorrect_d = 1'b0;
        mismatch_d  = 1'b0;
        case (state)
            ST_LOCKED, ST_NEW_PW, ST_VERIFY_PW: begin
                if (i_confirm) begin
                    if (full) begin
                        entry_clr = 1'b1;
                        if (state == ST_LOCKED) begin
                            if (entry == code_q) begin
                                next_state = ST_OPEN;
                                trials_d   = TRIALS_INIT;
                            end else begin
                                incorrect_d = 1'b1;
                                trials_d    = trials_dec;
                                if (trials_dec == 4'd0)
                                    next_state = ST_LOCKOUT;
                            end
                        end else if (state == ST_NEW_PW) begin
                            pend_d     = entry;
                            next_state = ST_VERIFY_PW;
                        end else begin
                            next_state = ST_OPEN;
                            if (entry == pend_q) begin
                                code_d = pend_q;
                            end else begin
                                mismatch_d = 1'b1;
                                pend_d     = '0;
                            end
                        end
                    end
                end else if (i_clear) begin
                    entry_clr = 1'b1;
                end else begin
                    digit_en = i_digit_valid;
                end
            end
            ST_OPEN: begin
                if (i_confirm) begin
                    next_state = ST_LOCKED;
                end else if (i_change) begin
                    next_state = ST_NEW_PW;
                    entry_clr  = 1'b1;
                end else if (timeout_hit) begin
                    next_state = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt == LOCK_LAST) begin
                    next_state = ST_LOCKED;
                    trials_d   = TRIALS_INIT;
                end
            end
            default: begin
                next_state = ST_LOCKED;
                entry_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_LOCKED;
            code_q       <= DEFAULT_PW;
            pend_q       <= '0;
            trials_q     <= TRIALS_INIT;
            lock_cnt     <= '0;
            open_cnt     <= '0;
            o_incorrect  <= 1'b0;
            o_mismatch   <= 1'b0;
            o_correct    <= 1'b0;
            o_locked_out <= 1'b0;
        end else begin
            state        <= next_state;
            code_q       <= code_d;
            pend_q       <= pend_d;
            trials_q     <= trials_d;
            o_incorrect  <= incorrect_d;
            o_mismatch   <= mismatch_d;
            o_correct    <= (next_state == ST_OPEN);
            o_locked_out <= (next_state == ST_LOCKOUT);
            // Both counters restart from zero whenever their state is left.
            lock_cnt <= (state == ST_LOCKOUT && next_state == ST_LOCKOUT)
                        ? lock_cnt + LOCK_W'(1) : '0;
            open_cnt <= ((OPEN_TIMEOUT > 0) && state == ST_OPEN && next_state == ST_OPEN)
                        ? open_cnt + OPEN_W'(1) : '0;
        end
    end

    assign o_state       = state;
    assign o_entry       = entry;
    assign o_digit_count = count;
    assign o_trials_left = trials_q;

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Directed bench for digital_lock_ctrl: one instance without auto-relock and
// one with a 50-cycle open timeout, both driven by the same stimulus.
module tb_digital_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        digit_valid = 1'b0;
    logic        confirm = 1'b0;
    logic        change = 1'b0;
    logic        clear = 1'b0;

    logic [11:0] entry, entry2;
    logic [1:0]  cnt, cnt2;
    logic [2:0]  state, state2;
    logic [3:0]  trials, trials2;
    logic        correct, correct2, incorrect, incorrect2;
    logic        mismatch, mismatch2, locked_out, locked_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digital_lock_ctrl #(
        .NUM_DIGITS(3), .DEFAULT_PW(12'h123), .MAX_TRIALS(3),
        .LOCKOUT_CYCLES(20), .OPEN_TIMEOUT(0)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_digit(digit), .i_digit_valid(digit_valid),
        .i_confirm(confirm), .i_change(change), .i_clear(clear),
        .o_entry(entry), .o_digit_count(cnt), .o_state(state),
        .o_trials_left(trials), .o_correct(correct), .o_incorrect(incorrect),
        .o_mismatch(mismatch), .o_locked_out(locked_out)
    );

    digital_lock_ctrl #(
        .NUM_DIGITS(3), .DEFAULT_PW(12'h123), .MAX_TRIALS(3),
        .LOCKOUT_CYCLES(20), .OPEN_TIMEOUT(50)
    ) dut_to (
        .i_clk(clk), .i_reset(rst), .i_digit(digit), .i_digit_valid(digit_valid),
        .i_confirm(confirm), .i_change(change), .i_clear(clear),
        .o_entry(entry2), .o_digit_count(cnt2), .o_state(state2),
        .o_trials_left(trials2), .o_correct(correct2), .o_incorrect(incorrect2),
        .o_mismatch(mismatch2), .o_locked_out(locked_out2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set before step() are sampled on the next edge; outputs read 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit = d; digit_valid = 1'b1; step(); digit_valid = 1'b0;
    endtask

    task automatic do_confirm();
        confirm = 1'b1; step(); confirm = 1'b0;
    endtask

    task automatic code3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        key(a); key(b); key(c); do_confirm();
    endtask

    task automatic do_change();
        change = 1'b1; step(); change = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_trials", trials, 3);
        chk("rst_entry", entry, 0);
        chk("rst_count", cnt, 0);
        chk("rst_correct", correct, 0);
        chk("rst_lockout", locked_out, 0);
        chk("rst_incorrect", incorrect, 0);

        // 1: correct code opens, confirm relocks
        key(1); key(2); key(3);
        chk("s1_entry", entry, 12'h123);
        chk("s1_count", cnt, 3);
        do_confirm();
        chk("s1_state_open", state, 1);
        chk("s1_correct", correct, 1);
        chk("s1_trials", trials, 3);
        chk("s1_entry_clr", entry, 0);
        do_confirm();
        chk("s1_relock", state, 0);
        chk("s1_correct_lo", correct, 0);

        // 2: three wrong attempts, lockout of exactly 20 cycles
        code3(4, 5, 6);
        chk("s2_inc1", incorrect, 1);
        chk("s2_tr1", trials, 2);
        step();
        chk("s2_inc1_pulse", incorrect, 0);
        code3(4, 5, 6);
        chk("s2_inc2", incorrect, 1);
        chk("s2_tr2", trials, 1);
        code3(4, 5, 6);
        chk("s2_inc3", incorrect, 1);
        chk("s2_tr3", trials, 0);
        chk("s2_lockout_state", state, 4);
        chk("s2_locked_out", locked_out, 1);
        key(7); key(8); key(9);
        chk("s2_lk_entry", entry, 0);
        chk("s2_lk_count", cnt, 0);
        repeat (16) step();
        chk("s2_lk_last", state, 4);
        step();
        chk("s2_lk_exit", state, 0);
        chk("s2_lk_trials", trials, 3);
        chk("s2_lk_level", locked_out, 0);

        // 3: short confirm, non-BCD digit, overflow digit
        key(1); key(2);
        do_confirm();
        chk("s3_short_state", state, 0);
        chk("s3_short_trials", trials, 3);
        chk("s3_short_count", cnt, 2);
        chk("s3_short_entry", entry, 12'h012);
        key(4'hA);
        chk("s3_nonbcd_count", cnt, 2);
        key(3);
        chk("s3_entry", entry, 12'h123);
        key(4);
        chk("s3_over_entry", entry, 12'h123);
        chk("s3_over_count", cnt, 3);
        clear = 1'b1; step(); clear = 1'b0;
        chk("s3_clear", entry, 0);

        // 4: code change, then a failed verification
        code3(1, 2, 3);
        chk("s4_open", state, 1);
        do_change();
        chk("s4_newpw", state, 2);
        code3(9, 8, 7);
        chk("s4_verify", state, 3);
        chk("s4_verify_entry", entry, 0);
        code3(9, 8, 7);
        chk("s4_changed", state, 1);
        chk("s4_no_mismatch", mismatch, 0);
        do_confirm();
        code3(1, 2, 3);
        chk("s4_old_fails", incorrect, 1);
        chk("s4_old_trials", trials, 2);
        code3(9, 8, 7);
        chk("s4_new_opens", state, 1);
        chk("s4_new_trials", trials, 3);
        do_change();
        code3(1, 1, 1);
        code3(9, 8, 6);
        chk("s4_mismatch", mismatch, 1);
        chk("s4_mm_state", state, 1);
        step();
        chk("s4_mm_pulse", mismatch, 0);
        do_confirm();
        code3(9, 8, 7);
        chk("s4_code_kept", state, 1);
        do_confirm();
        chk("s4_relock", state, 0);

        // 5: same-cycle pulses and reset in the middle of activity
        key(1); key(2);
        digit = 4'd3; digit_valid = 1'b1; confirm = 1'b1; step();
        digit_valid = 1'b0; confirm = 1'b0;
        chk("s5_conf_dig_count", cnt, 2);
        chk("s5_conf_dig_entry", entry, 12'h012);
        digit = 4'd5; digit_valid = 1'b1; clear = 1'b1; step();
        digit_valid = 1'b0; clear = 1'b0;
        chk("s5_clr_dig_entry", entry, 0);
        chk("s5_clr_dig_count", cnt, 0);
        code3(4, 5, 6); code3(4, 5, 6); code3(4, 5, 6);
        chk("s5_lockout", state, 4);
        do_reset();
        chk("s5_rst_lk_state", state, 0);
        chk("s5_rst_lk_trials", trials, 3);
        chk("s5_rst_lk_level", locked_out, 0);
        code3(1, 2, 3);
        chk("s5_default_code", state, 1);
        do_change();
        code3(5, 5, 5);
        chk("s5_in_verify", state, 3);
        key(5);
        digit = 4'd5; digit_valid = 1'b1; rst = 1'b1; step();
        digit_valid = 1'b0; rst = 1'b0;
        chk("s5_rst_vf_state", state, 0);
        chk("s5_rst_vf_entry", entry, 0);
        chk("s5_rst_vf_count", cnt, 0);
        code3(1, 2, 3);
        chk("s5_code_restored", state, 1);
        do_confirm();

        // 6: auto-relock on the timeout instance
        do_reset();
        code3(1, 2, 3);
        chk("s6_open", state2, 1);
        chk("s6_correct", correct2, 1);
        repeat (49) step();
        chk("s6_still_open", state2, 1);
        step();
        chk("s6_timeout", state2, 0);
        chk("s6_correct_lo", correct2, 0);
        code3(1, 2, 3);
        repeat (40) step();
        do_change();
        chk("s6_newpw", state2, 2);
        repeat (20) step();
        code3(9, 8, 7);
        chk("s6_verify", state2, 3);
        code3(9, 8, 7);
        chk("s6_back_open", state2, 1);
        repeat (49) step();
        chk("s6_restart_open", state2, 1);
        step();
        chk("s6_restart_timeout", state2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digital_lock_ctrl.md
Name: digital_lock_ctrl

Overview:
Parametrised digital-lock controller: next-generation lock FSM with configurable code length, trial budget, timed lockout, auto-relock and in-field code change. It accepts one-cycle digit, confirm, change and clear pulses from upstream edge detectors. It drives status levels and pulses to the LED blinkers, and drives entry, count and state values to the 7-segment decoders.

Parameters:
NUM_DIGITS, 3, code length in BCD digits (1..8)
DEFAULT_PW, 12'h123, code loaded on reset; width 4*NUM_DIGITS, each nibble 0..9
MAX_TRIALS, 3, failed attempts allowed before lockout (1..15)
LOCKOUT_CYCLES, 250_000_000, cycles spent in LOCKOUT (>=1)
OPEN_TIMEOUT, 0, cycles in OPEN before auto-relock; 0 disables auto-relock

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_digit  in  4  BCD digit value
i_digit_valid  in  1  one-cycle pulse: accept i_digit
i_confirm  in  1  one-cycle pulse: submit entry / relock
i_change  in  1  one-cycle pulse: begin code change (OPEN only)
i_clear  in  1  one-cycle pulse: discard current entry
o_entry  out  4*NUM_DIGITS  entry register, newest digit in nibble 0
o_digit_count  out  $clog2(NUM_DIGITS+1)  digits entered so far
o_state  out  3  0=LOCKED 1=OPEN 2=NEW_PW 3=VERIFY_PW 4=LOCKOUT
o_trials_left  out  4  remaining attempts
o_correct  out  1  level, high while state==OPEN
o_incorrect  out  1  one-cycle pulse on failed unlock attempt
o_mismatch  out  1  one-cycle pulse when new-code verification fails
o_locked_out  out  1  level, high while state==LOCKOUT

Behaviour:
- Reset, when i_reset is high at a clock edge: state=LOCKED, stored code=DEFAULT_PW, entry=0, count=0, trials_left=MAX_TRIALS. Pending code, lockout counter and open counter are 0. o_incorrect=o_mismatch=0. Reset overrides all other inputs, including mid-lockout and mid-change.
- All outputs are registered. Effects appear on the cycle after the input pulse.
- Entry (LOCKED, NEW_PW, VERIFY_PW only):
  - i_digit_valid with i_digit<=9 and count<NUM_DIGITS: entry <= {entry[4*NUM_DIGITS-5:0], i_digit}, count+1.
  - Digits 10..15 are ignored.
  - Digits arriving at a full count are ignored.
- Input priority within one cycle: i_confirm > i_clear > i_digit_valid. A lower-priority pulse in the same cycle is dropped.
- i_clear: entry=0, count=0. Trials are unchanged.
- LOCKED, on i_confirm:
  - count<NUM_DIGITS: ignored; no trial consumed.
  - Full count and entry==stored code: go to OPEN, trials_left=MAX_TRIALS.
  - Full count and mismatch: pulse o_incorrect, trials_left-1. If the result is 0, go to LOCKOUT.
  - Entry and count are cleared in every case except the ignored case.
- OPEN:
  - i_confirm: go to LOCKED.
  - i_change: go to NEW_PW, clearing entry.
  - If OPEN_TIMEOUT>0, the open counter increments each cycle in OPEN. When it reaches OPEN_TIMEOUT-1, go to LOCKED. The counter clears on leaving OPEN.
  - i_digit_valid and i_clear are ignored.
- NEW_PW, on i_confirm with full count: pending code=entry, clear entry, go to VERIFY_PW. A short confirm is ignored.
- VERIFY_PW, on i_confirm with full count:
  - entry==pending: stored code=pending, go to OPEN.
  - Otherwise: pulse o_mismatch, discard pending, go to OPEN; stored code unchanged.
  - Entry is cleared in both cases. A short confirm is ignored.
- Open timeout is suspended in NEW_PW and VERIFY_PW. i_change outside OPEN is ignored.
- LOCKOUT:
  - All user inputs are ignored.
  - The counter runs 0..LOCKOUT_CYCLES-1. On the terminal count, go to LOCKED, trials_left=MAX_TRIALS, counter cleared.
  - Total LOCKOUT dwell is exactly LOCKOUT_CYCLES cycles.
- Comparisons use the full 4*NUM_DIGITS width.
- trials_left never underflows.
- Illegal state encodings (5..7) recover to LOCKED on the next cycle.

Decomposition:
- Package digital_lock_pkg: state encoding localparams (S_LOCKED..S_LOCKOUT), the 3-bit state width constant, and the BCD max digit (9).
- One sub-module, lock_entry_reg: shift register, digit counter and clear/full logic, parametrised by NUM_DIGITS.
- FSM, counters and code storage stay in the top.

Test Plan:
All scenarios use NUM_DIGITS=3, DEFAULT_PW=12'h123, MAX_TRIALS=3, LOCKOUT_CYCLES=20 unless stated.
1. After reset, enter digits 1,2,3, then confirm -> next cycle o_state=1, o_correct=1, o_trials_left=3, o_entry=0. Confirm again -> o_state=0.
2. Submit 4,5,6 three times -> o_incorrect pulses each time, o_trials_left goes 2,1,0. After the third attempt: o_state=4, o_locked_out=1 for exactly 20 cycles, then o_state=0, o_trials_left=3. Digits entered during lockout have no effect.
3. Enter 1,2 then confirm -> ignored, o_trials_left=3, o_digit_count=2. Then digit 0xA and digit 3 -> o_entry=12'h123. A fourth digit is ignored.
4. Unlock, i_change, enter 9,8,7, confirm, enter 9,8,7, confirm -> o_state=1. Relock: 1,2,3 now fails (o_incorrect), 9,8,7 opens. Repeat with a verify entry of 9,8,6 -> o_mismatch pulse and the code stays 987.
5. Same-cycle pulses: confirm together with digit_valid -> digit dropped. Clear together with digit_valid -> entry=0. Reset asserted during LOCKOUT and during VERIFY_PW -> reset values next cycle, stored code=12'h123.
6. OPEN_TIMEOUT=50 -> after unlock, o_state returns to 0 exactly 50 cycles later. A change sequence started before the timeout is not interrupted by it.
